// File: rtl/vedic_mac_accumulator.sv
// Purpose: sums a programmed number of unsigned products from the Vedic multiplier into a wide accumulator.
// Latency: out_valid rises the cycle after the final product transfer; the next start is accepted 2 cycles after that transfer at the earliest.
// Backpressure: prod_ready is high only in ACCUM; the result is held in DONE until out_ready, and start is ignored while busy.
//
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start         : one-cycle pulse, honoured only in IDLE
//   num_terms     : number of products to sum, sampled on an accepted start
//   prod_valid    : prod_in carries a product this cycle
//   prod_in       : unsigned product (PROD_W bits)
//   prod_ready    : block consumes prod_in this cycle (registered)
//   acc_out       : accumulator register, meaningful when out_valid=1
//   out_valid     : final sum available (registered)
//   out_ready     : consumer accepts the result
//   busy          : high in ACCUM or DONE (registered)
//   overflow      : sticky carry out of ACC_W for the current accumulation
module vedic_mac_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 80,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_in,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // One extra bit on the adder captures the carry out of the accumulator;
  // the product is zero-extended to the full accumulator width.
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    sum_ext = '0;
    sum_ext = {1'b0, acc_out} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
  end

  // prod_ready, out_valid and busy are registered alongside the state so
  // that no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_out    <= '0;
      count      <= '0;
      prod_ready <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (num_terms != '0) begin
              count      <= num_terms;
              state      <= ACCUM;
              prod_ready <= 1'b1;
            end else begin
              // Empty sum: present zero immediately.
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (prod_valid) begin
            acc_out  <= sum_ext[ACC_W-1:0];
            overflow <= overflow | sum_ext[ACC_W];
            count    <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              out_valid  <= 1'b1;
            end
          end
        end

        DONE: begin
          // start is deliberately not looked at here; a start coinciding
          // with out_ready is dropped rather than queued.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          prod_ready <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
module tb_vedic_mac_accumulator;

  localparam int PROD_W = 64;
  localparam int ACC_W  = 80;
  localparam int CNT_W  = 16;
  localparam logic [63:0] P = 64'hFFFFFFFE00000001;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_terms;
  logic              prod_valid;
  logic [PROD_W-1:0] prod_in;
  logic              out_ready;

  logic              prod_ready, out_valid, busy, overflow;
  logic [ACC_W-1:0]  acc_out;
  logic              prod_ready64, out_valid64, busy64, overflow64;
  logic [63:0]       acc_out64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vedic_mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .prod_valid(prod_valid), .prod_in(prod_in), .prod_ready(prod_ready),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow)
  );

  // Narrow accumulator instance used to exercise wrap-around.
  vedic_mac_accumulator #(.PROD_W(PROD_W), .ACC_W(64), .CNT_W(CNT_W)) dut64 (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .prod_valid(prod_valid), .prod_in(prod_in), .prod_ready(prod_ready64),
    .acc_out(acc_out64), .out_valid(out_valid64), .out_ready(out_ready),
    .busy(busy64), .overflow(overflow64)
  );

  typedef struct packed {
    logic              st;
    logic [CNT_W-1:0]  nt;
    logic              pv;
    logic [PROD_W-1:0] pin;
    logic              ordy;
    logic              e_pr;
    logic              e_ov;
    logic              e_busy;
    logic [ACC_W-1:0]  e_acc;
    logic              e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [CNT_W-1:0] nt, input logic pv,
                     input logic [PROD_W-1:0] pin, input logic ordy,
                     input logic e_pr, input logic e_ov, input logic e_busy,
                     input logic [ACC_W-1:0] e_acc, input logic e_ovf);
    vec_t v;
    v = '{st, nt, pv, pin, ordy, e_pr, e_ov, e_busy, e_acc, e_ovf};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic r, input logic st, input logic [CNT_W-1:0] nt,
                      input logic pv, input logic [PROD_W-1:0] pin, input logic ordy);
    rst = r; start = st; num_terms = nt; prod_valid = pv; prod_in = pin; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_pr, input logic e_ov,
                           input logic e_busy, input logic [ACC_W-1:0] e_acc, input logic e_ovf);
    check({tag, "_prod_ready"}, ACC_W'(prod_ready), ACC_W'(e_pr));
    check({tag, "_out_valid"},  ACC_W'(out_valid),  ACC_W'(e_ov));
    check({tag, "_busy"},       ACC_W'(busy),       ACC_W'(e_busy));
    check({tag, "_acc"},        acc_out,            e_acc);
    check({tag, "_overflow"},   ACC_W'(overflow),   ACC_W'(e_ovf));
  endtask

  initial begin
    // Basic sum: four FFFFFFFF^2 products back to back.
    add(1, 4, 0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 1, P, 0,   1, 0, 1, 80'h0FFFFFFFE00000001, 0);
    add(0, 0, 1, P, 0,   1, 0, 1, 80'h1FFFFFFFC00000002, 0);
    add(0, 0, 1, P, 0,   1, 0, 1, 80'h2FFFFFFFA00000003, 0);
    add(0, 0, 1, P, 0,   0, 1, 1, 80'h3FFFFFFF800000004, 0);
    add(0, 0, 0, 0, 1,   0, 0, 0, 80'h3FFFFFFF800000004, 0);
    // Bubbles: 5, 7, 11 with two idle cycles between; out_ready on the final transfer has no effect.
    add(1, 3, 0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 1, 5, 0,   1, 0, 1, 5, 0);
    add(0, 0, 0, 99, 0,  1, 0, 1, 5, 0);
    add(0, 0, 0, 99, 0,  1, 0, 1, 5, 0);
    add(0, 0, 1, 7, 0,   1, 0, 1, 12, 0);
    add(0, 0, 0, 99, 0,  1, 0, 1, 12, 0);
    add(0, 0, 0, 99, 0,  1, 0, 1, 12, 0);
    add(0, 0, 1, 11, 1,  0, 1, 1, 23, 0);
    add(0, 0, 0, 0, 0,   0, 1, 1, 23, 0);
    add(0, 0, 0, 0, 1,   0, 0, 0, 23, 0);
    // Backpressure: hold DONE with 0x10 while start and prod_valid are driven.
    add(1, 1, 0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 1, 16, 0,  0, 1, 1, 16, 0);
    for (int i = 0; i < 5; i++)
      add(1, 5, 1, 64'h99, 0, 0, 1, 1, 16, 0);
    add(1, 5, 1, 64'h99, 1, 0, 0, 0, 16, 0);
    add(0, 0, 1, 64'h99, 0, 0, 0, 0, 16, 0);
    // Zero terms: straight to DONE with zero; offered product not consumed.
    add(1, 0, 1, 64'h55, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 64'h55, 1, 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset_dut64_acc", ACC_W'(acc_out64), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].st, tbl[i].nt, tbl[i].pv, tbl[i].pin, tbl[i].ordy);
      check_all($sformatf("v%0d", i), tbl[i].e_pr, tbl[i].e_ov, tbl[i].e_busy, tbl[i].e_acc, tbl[i].e_ovf);
    end

    // Overflow on the 64-bit accumulator; the 80-bit one holds the full sum.
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, P, 0);
    check("ovf_first_overflow64", ACC_W'(overflow64), 0);
    step(0, 0, 0, 1, P, 0);
    check("ovf_acc64", ACC_W'(acc_out64), ACC_W'(64'hFFFFFFFC00000002));
    check("ovf_overflow64", ACC_W'(overflow64), 1);
    check("ovf_out_valid64", ACC_W'(out_valid64), 1);
    check("ovf_acc80", acc_out, 80'h1FFFFFFFC00000002);
    check("ovf_overflow80", ACC_W'(overflow), 0);
    step(0, 0, 0, 0, 0, 1);
    check("ovf_held_in_idle", ACC_W'(overflow64), 1);
    check("ovf_idle_busy", ACC_W'(busy64), 0);
    step(0, 1, 1, 0, 0, 0);
    check("ovf_cleared_by_start", ACC_W'(overflow64), 0);
    check("ovf_start_acc", ACC_W'(acc_out64), 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0, 1);

    // Reset mid-run after three of eight transfers.
    step(0, 1, 8, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    check("midrun_acc", acc_out, 3);
    step(1, 0, 0, 1, 1, 0);
    check_all("midrun_reset", 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check_all("restart", 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 9, 0);
    check_all("restart_done", 0, 1, 1, 9, 0);
    step(0, 0, 0, 0, 0, 1);
    check("restart_idle_valid", ACC_W'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/vedic_mac_accumulator.md
Name: vedic_mac_accumulator

Overview:
- Downstream stage of the 32x32 Vedic multiplier. Consumes its 64-bit unsigned product stream and sums a programmed number of products into a wide accumulator.
- Presents the final sum on a valid/ready output handshake.
- Forms the accumulate half of the multiply-accumulate datapath. It captures one product per cycle when the multiplier's registered Product is flagged valid.

Parameters:
- PROD_W, 64, width of incoming product (matches the multiplier's Product).
- ACC_W, 80, accumulator/result width; must be >= PROD_W.
- CNT_W, 16, width of the term counter and num_terms.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new accumulation; honoured only in IDLE.
- num_terms  input  CNT_W  number of products to sum; sampled when start is accepted.
- prod_valid  input  1  prod_in carries a valid product this cycle.
- prod_in  input  PROD_W  unsigned product from the multiplier.
- prod_ready  output  1  block accepts a product this cycle.
- acc_out  output  ACC_W  accumulator register; meaningful when out_valid=1.
- out_valid  output  1  final sum available.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in ACCUM or DONE.
- overflow  output  1  sticky; carry out of ACC_W occurred during the current accumulation.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - acc_out=0, count=0, prod_ready=0, out_valid=0, busy=0, overflow=0.
  - Reset overrides every other input and aborts any accumulation in progress. The partial sum is discarded.
- All outputs are registered or decoded from state only. No combinational path runs from inputs to outputs.
- States:
  - IDLE: prod_ready=0, out_valid=0, busy=0.
    - start=1 and num_terms!=0: next cycle acc=0, overflow=0, count=num_terms, go to ACCUM.
    - start=1 and num_terms==0: next cycle acc=0, overflow=0, go to DONE.
  - ACCUM: prod_ready=1, busy=1.
    - A transfer occurs on any cycle with prod_valid=1.
    - On transfer: acc <= acc + zero-extended prod_in, truncated to ACC_W. overflow |= carry out of bit ACC_W-1. count decrements.
    - If the transfer occurs with count==1, go to DONE.
    - Cycles with prod_valid=0 change nothing. Bubbles of any length are allowed.
  - DONE: out_valid=1, busy=1, prod_ready=0.
    - acc_out and overflow are held stable.
    - On out_ready=1, go to IDLE; out_valid is 0 in the next cycle.
    - overflow keeps its value until the next accepted start.
- Latency: out_valid asserts on the cycle after the final product transfer. With out_ready held high, the earliest next start is accepted 2 cycles after that transfer.
- start in ACCUM or DONE is ignored and num_terms is not sampled. There is no queuing.
- Arithmetic is unsigned only. Wrap-around is modulo 2^ACC_W and is flagged through overflow. The block never saturates.
- prod_in is ignored whenever prod_ready=0.
- Upstream must hold a product until it sees prod_ready=1. Products offered outside ACCUM are not consumed.
- Simultaneous events:
  - Final transfer and out_ready in the same cycle: out_ready has no effect, because the block is not yet in DONE.
  - out_ready and start in the same cycle while in DONE: the block returns to IDLE and start is dropped.

Test Plan:
- Basic sum: reset, start with num_terms=4, four back-to-back prod_in=0xFFFFFFFE00000001 (FFFFFFFF squared) -> out_valid one cycle after the 4th transfer, acc_out=0x3_FFFFFFF8_00000004, overflow=0.
- Bubbles: num_terms=3, products 5, 7, 11 with prod_valid low for 2 cycles between each -> acc_out=23 only after the 3rd transfer; prod_ready high throughout ACCUM.
- Backpressure: reach DONE with sum 0x10, hold out_ready=0 for 5 cycles while pulsing start and driving prod_valid -> acc_out stays 0x10, out_valid stays 1, prod_ready stays 0, no new run. Then out_ready=1 -> IDLE next cycle.
- Zero terms: start with num_terms=0 -> DONE next cycle with acc_out=0; prod_in is never accepted.
- Overflow (ACC_W=64): num_terms=2, both products 0xFFFFFFFE00000001 -> acc_out=0xFFFFFFFC00000002, overflow=1. The next start clears overflow.
- Reset mid-run: num_terms=8, assert rst after 3 transfers -> all outputs 0 and state IDLE next cycle. A new start with num_terms=1 and product 9 -> acc_out=9.
